// File: rtl/ama_riscv_dmem_pkg.sv
// Shared encodings and response-register layout for the data memory arbiter.
package ama_riscv_dmem_pkg;

  localparam int SIZE_W = 2;
  localparam int OFF_W  = 2;
  localparam int PORT_W = 1;
  localparam int WCNT_W = 8;

  localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

  localparam logic [PORT_W-1:0] P_CORE = 1'b0;
  localparam logic [PORT_W-1:0] P_HOST = 1'b1;

  // Everything the response cycle needs to know about the accepted request
  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] port;
    logic              err;
    logic              we;
    logic [SIZE_W-1:0] size;
    logic              sign;
    logic [OFF_W-1:0]  off;
  } rsp_reg_t;

  // Illegal size or an access not aligned to its own size
  function automatic logic size_err(input logic [SIZE_W-1:0] size,
                                    input logic [OFF_W-1:0]  off);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = off[0];
      SZ_W:    err = (off != 2'd0);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/ama_riscv_dmem_align.sv
// Byte-lane alignment: store lane placement + byte enables (LOAD=0), or
// load lane extraction + sign/zero extension (LOAD=1).
module ama_riscv_dmem_align
  import ama_riscv_dmem_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [SIZE_W-1:0] size,
  input  logic [OFF_W-1:0]  off,
  input  logic              sign,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [3:0]        be
);

  generate
    if (LOAD) begin : g_load
      logic [31:0] shifted;
      assign shifted = din >> {off, 3'b000};

      // Truncate the addressed lanes to the access size and extend
      always_comb begin
        be = 4'b0000;
        case (size)
          SZ_B:    dout = {{24{sign & shifted[7]}}, shifted[7:0]};
          SZ_H:    dout = {{16{sign & shifted[15]}}, shifted[15:0]};
          default: dout = shifted;
        endcase
      end
    end else begin : g_store
      // Replicating the right-aligned data puts it in every candidate lane;
      // the byte enables pick the lanes that are actually written
      always_comb begin
        case (size)
          SZ_B: begin
            dout = {4{din[7:0]}};
            be   = 4'b0001 << off;
          end
          SZ_H: begin
            dout = {2{din[15:0]}};
            be   = 4'b0011 << off;
          end
          SZ_W: begin
            dout = din;
            be   = 4'b1111;
          end
          default: begin
            dout = din;
            be   = 4'b0000;
          end
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/ama_riscv_dmem_arb.sv
// Two-port arbiter in front of the single-port data memory: core (port 0)
// has priority unless the host has waited too long. Responses come back
// exactly one cycle after acceptance to the port that issued the request.
module ama_riscv_dmem_arb
  import ama_riscv_dmem_pkg::*;
#(
  parameter int AW            = 16,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic [AW-1:0] p0_req_addr,
  input  logic          p0_req_we,
  input  logic [1:0]    p0_req_size,
  input  logic          p0_req_sign,
  input  logic [31:0]   p0_req_wdata,
  output logic          p0_rsp_valid,
  output logic [31:0]   p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic [AW-1:0] p1_req_addr,
  input  logic          p1_req_we,
  input  logic [1:0]    p1_req_size,
  input  logic          p1_req_sign,
  input  logic [31:0]   p1_req_wdata,
  output logic          p1_rsp_valid,
  output logic [31:0]   p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  localparam logic [WCNT_W-1:0] MAX_WAIT = WCNT_W'(HOST_MAX_WAIT);
  localparam logic [WCNT_W-1:0] WCNT_SAT = {WCNT_W{1'b1}};

  logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  rsp_reg_t          rsp_reg, rsp_next;

  logic              host_force, accept, req_err, issue;
  logic [PORT_W-1:0] sel_port;
  logic [AW-1:0]     req_addr;
  logic              req_we, req_sign;
  logic [SIZE_W-1:0] req_size;
  logic [31:0]       req_wdata;
  logic [31:0]       st_data, ld_data, rsp_data;
  logic [3:0]        st_be, ld_be_unused;

  // Grant depends only on the valids and the host wait counter
  assign host_force   = p1_req_valid && (wait_cnt_reg >= MAX_WAIT);
  assign p1_req_ready = p1_req_valid && (host_force || !p0_req_valid);
  assign p0_req_ready = p0_req_valid && !p1_req_ready;
  assign accept       = p0_req_ready || p1_req_ready;
  assign sel_port     = p1_req_ready ? P_HOST : P_CORE;

  // Steer the granted port's request fields onto the shared path
  always_comb begin
    if (sel_port == P_HOST) begin
      req_addr  = p1_req_addr;
      req_we    = p1_req_we;
      req_size  = p1_req_size;
      req_sign  = p1_req_sign;
      req_wdata = p1_req_wdata;
    end else begin
      req_addr  = p0_req_addr;
      req_we    = p0_req_we;
      req_size  = p0_req_size;
      req_sign  = p0_req_sign;
      req_wdata = p0_req_wdata;
    end
  end

  assign req_err = size_err(req_size, req_addr[1:0]);
  assign issue   = accept && !req_err;

  ama_riscv_dmem_align #(.LOAD(1'b0)) u_store_align (
    .size (req_size),
    .off  (req_addr[1:0]),
    .sign (req_sign),
    .din  (req_wdata),
    .dout (st_data),
    .be   (st_be)
  );

  // Erroring requests are accepted but never touch the memory
  assign mem_en   = issue;
  assign mem_we   = (issue && req_we) ? st_be : 4'b0000;
  assign mem_addr = req_addr[AW-1:2];
  assign mem_din  = st_data;

  // Host starvation counter: counts denied host cycles, saturating
  always_comb begin
    if (p1_req_valid && !p1_req_ready)
      wait_cnt_next = (wait_cnt_reg == WCNT_SAT) ? WCNT_SAT : wait_cnt_reg + 1'b1;
    else
      wait_cnt_next = '0;
  end

  // Capture what the response cycle needs at the accepting edge
  always_comb begin
    rsp_next.valid = accept;
    rsp_next.port  = sel_port;
    rsp_next.err   = req_err;
    rsp_next.we    = req_we;
    rsp_next.size  = req_size;
    rsp_next.sign  = req_sign;
    rsp_next.off   = req_addr[1:0];
  end

  // State update; reset drops any pending response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      rsp_reg      <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      rsp_reg      <= rsp_next;
    end
  end

  ama_riscv_dmem_align #(.LOAD(1'b1)) u_load_align (
    .size (rsp_reg.size),
    .off  (rsp_reg.off),
    .sign (rsp_reg.sign),
    .din  (mem_dout),
    .dout (ld_data),
    .be   (ld_be_unused)
  );

  assign rsp_data = (rsp_reg.err || rsp_reg.we) ? 32'd0 : ld_data;

  assign p0_rsp_valid = rsp_reg.valid && (rsp_reg.port == P_CORE);
  assign p1_rsp_valid = rsp_reg.valid && (rsp_reg.port == P_HOST);
  assign p0_rsp_rdata = p0_rsp_valid ? rsp_data : 32'd0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_data : 32'd0;
  assign p0_rsp_err   = p0_rsp_valid && rsp_reg.err;
  assign p1_rsp_err   = p1_rsp_valid && rsp_reg.err;

endmodule

// File: tb/tb_ama_riscv_dmem_arb.sv
// Scoreboard bench for ama_riscv_dmem_arb: stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_ama_riscv_dmem_arb;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req_valid, p0_req_ready, p0_req_we, p0_req_sign;
  logic [AW-1:0] p0_req_addr;
  logic [1:0]    p0_req_size;
  logic [31:0]   p0_req_wdata;
  logic          p0_rsp_valid, p0_rsp_err;
  logic [31:0]   p0_rsp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_we, p1_req_sign;
  logic [AW-1:0] p1_req_addr;
  logic [1:0]    p1_req_size;
  logic [31:0]   p1_req_wdata;
  logic          p1_rsp_valid, p1_rsp_err;
  logic [31:0]   p1_rsp_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t q[$];

  logic [31:0] mem [0:(1<<(AW-2))-1];

  always #5 clk = ~clk;

  ama_riscv_dmem_arb #(.AW(AW), .HOST_MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_addr(p0_req_addr), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_sign(p0_req_sign),
    .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_addr(p1_req_addr), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_sign(p1_req_sign),
    .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Memory model: 1-cycle synchronous read, byte write enables
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (p0_rsp_valid || p1_rsp_valid) begin
      chk("rsp_one_port", {31'd0, p0_rsp_valid & p1_rsp_valid}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=p0:%0b/p1:%0b required=none", p0_rsp_valid, p1_rsp_valid);
      end else begin
        e = q.pop_front();
        chk("rsp_port", {31'd0, p1_rsp_valid}, {31'd0, e.port});
        chk("rsp_rdata", e.port ? p1_rsp_rdata : p0_rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, e.port ? p1_rsp_err : p0_rsp_err}, {31'd0, e.err});
        $display("rsp port=%0d rdata=%h err=%0b (exp %h/%0b)", e.port,
                 e.port ? p1_rsp_rdata : p0_rsp_rdata,
                 e.port ? p1_rsp_err : p0_rsp_err, e.rdata, e.err);
      end
    end
  end

  task automatic set_req(input bit port, input bit v, input logic [15:0] addr, input bit we,
                         input logic [1:0] size, input bit sign, input logic [31:0] wdata);
    if (port) begin
      p1_req_valid = v; p1_req_addr = addr; p1_req_we = we;
      p1_req_size = size; p1_req_sign = sign; p1_req_wdata = wdata;
    end else begin
      p0_req_valid = v; p0_req_addr = addr; p0_req_we = we;
      p0_req_size = size; p0_req_sign = sign; p0_req_wdata = wdata;
    end
  endtask

  // Issue one request; checks the memory drive in the accepting cycle
  task automatic issue(input bit port, input logic [15:0] addr, input bit we,
                       input logic [1:0] size, input bit sign, input logic [31:0] wdata,
                       input bit exp_en, input logic [3:0] exp_we, input logic [31:0] exp_din,
                       input logic [31:0] exp_rdata, input bit exp_err);
    exp_t e;
    bit got = 0;
    @(negedge clk);
    set_req(port, 1'b1, addr, we, size, sign, wdata);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (port ? p1_req_ready : p0_req_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 port=%0d", port);
      set_req(port, 1'b0, addr, we, size, sign, wdata);
      return;
    end
    chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
    chk("mem_we", {28'd0, mem_we}, {28'd0, exp_we});
    if (exp_en) chk("mem_addr", {18'd0, mem_addr}, {18'd0, addr[15:2]});
    if (exp_we != 4'b0) chk("mem_din", mem_din, exp_din);
    e.port = port; e.rdata = exp_rdata; e.err = exp_err;
    q.push_back(e);
    $display("req port=%0d addr=%h we=%0b size=%0d sign=%0b wdata=%h", port, addr, we, size, sign, wdata);
    @(posedge clk);
    #1;
    set_req(port, 1'b0, addr, we, size, sign, wdata);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < (1 << (AW-2)); i++) mem[i] = 32'd0;
    mem[8] = 32'h11223344;
    mem[9] = 32'hA5A55A5A;
    mem_dout = 32'd0;
    set_req(1'b0, 1'b0, 16'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    set_req(1'b1, 1'b0, 16'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_p0_rsp_valid", {31'd0, p0_rsp_valid}, 32'd0);
    chk("reset_p1_rsp_valid", {31'd0, p1_rsp_valid}, 32'd0);
    chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset_ready", {30'd0, p0_req_ready, p1_req_ready}, 32'd0);
    rst = 1'b0;

    // Word store then word load
    issue(0, 16'h0010, 1, 2'd2, 0, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 16'h0010, 0, 2'd2, 0, 32'h0, 1, 4'h0, 32'h0, 32'hDEADBEEF, 0);
    // Byte store into lane 3, signed and unsigned byte loads
    issue(0, 16'h0013, 1, 2'd0, 0, 32'h00000080, 1, 4'b1000, 32'h80808080, 32'h0, 0);
    issue(0, 16'h0013, 0, 2'd0, 1, 32'h0, 1, 4'h0, 32'h0, 32'hFFFFFF80, 0);
    issue(0, 16'h0013, 0, 2'd0, 0, 32'h0, 1, 4'h0, 32'h0, 32'h00000080, 0);
    // Signed half load of upper half (0x80AD)
    issue(0, 16'h0012, 0, 2'd1, 1, 32'h0, 1, 4'h0, 32'h0, 32'hFFFF80AD, 0);
    // Misaligned half load / store and illegal size: errors, no memory effect
    issue(0, 16'h0011, 0, 2'd1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
    issue(0, 16'h0011, 1, 2'd1, 0, 32'h0000FFFF, 0, 4'h0, 32'h0, 32'h0, 1);
    issue(1, 16'h0010, 1, 2'd3, 0, 32'hFFFFFFFF, 0, 4'h0, 32'h0, 32'h0, 1);
    issue(0, 16'h0010, 0, 2'd2, 0, 32'h0, 1, 4'h0, 32'h0, 32'h80ADBEEF, 0);
    // Host half store to upper half of word 5, then word readback
    issue(1, 16'h0016, 1, 2'd1, 0, 32'h00001234, 1, 4'b1100, 32'h12341234, 32'h0, 0);
    issue(1, 16'h0014, 0, 2'd2, 0, 32'h0, 1, 4'h0, 32'h0, 32'h12340000, 0);

    // Starvation: both ports requesting continuously
    @(negedge clk);
    set_req(0, 1'b1, 16'h0010, 0, 2'd2, 0, 32'h0);
    set_req(1, 1'b1, 16'h0010, 0, 2'd2, 0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("grant_p1_cyc%0d", i), {31'd0, p1_req_ready}, {31'd0, i == 8});
      chk($sformatf("grant_p0_cyc%0d", i), {31'd0, p0_req_ready}, {31'd0, i != 8});
      if (i == 9) chk("wait_cnt_cleared", {24'd0, dut.wait_cnt_reg}, 32'd0);
      e.port = p1_req_ready; e.rdata = 32'h80ADBEEF; e.err = 0;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
    end
    set_req(0, 1'b0, 16'h0, 0, 2'd0, 0, 32'h0);
    set_req(1, 1'b0, 16'h0, 0, 2'd0, 0, 32'h0);
    repeat (2) @(negedge clk);

    // Back-to-back: p0 load 0x20 then p1 load 0x24 on consecutive edges
    set_req(0, 1'b1, 16'h0020, 0, 2'd2, 0, 32'h0);
    e.port = 0; e.rdata = 32'h11223344; e.err = 0; q.push_back(e);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0020, 0, 2'd2, 0, 32'h0);
    set_req(1, 1'b1, 16'h0024, 0, 2'd2, 0, 32'h0);
    e.port = 1; e.rdata = 32'hA5A55A5A; e.err = 0; q.push_back(e);
    @(negedge clk);
    chk("b2b_p0_rsp", {31'd0, p0_rsp_valid}, 32'd1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 16'h0024, 0, 2'd2, 0, 32'h0);
    @(negedge clk);
    chk("b2b_p1_rsp", {31'd0, p1_rsp_valid}, 32'd1);

    // Reset right after a load acceptance drops its response
    @(negedge clk);
    set_req(0, 1'b1, 16'h0010, 0, 2'd2, 0, 32'h0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0010, 0, 2'd2, 0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp_valid", {30'd0, p0_rsp_valid, p1_rsp_valid}, 32'd0);
    chk("rst_mid_rdata", p0_rsp_rdata, 32'd0);
    chk("rst_mid_mem", {27'd0, mem_en, mem_we}, 32'd0);
    chk("rst_mid_wait_cnt", {24'd0, dut.wait_cnt_reg}, 32'd0);
    rst = 1'b0;
    issue(0, 16'h0010, 0, 2'd2, 0, 32'h0, 1, 4'h0, 32'h0, 32'h80ADBEEF, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ama_riscv_dmem_arb.md
Name: ama_riscv_dmem_arb

Overview:
- Arbitrates the single-port data memory between two requesters: port 0 = core load/store unit, port 1 = host/debug loader.
- Converts byte-addressed, sized requests into word address, byte write-enables and lane-shifted write data for the memory.
- Returns aligned and sign/zero-extended load data to the requester that issued the request.
- Sits between the core memory stage plus the host bridge and the data memory, which is 32-bit wide, 1-cycle synchronous read, with byte write enables.

Parameters:
- AW, 16, byte-address width; word address to memory is AW-2 = 14 bits.
- HOST_MAX_WAIT, 8, cycles a pending host request may be denied before the host gets forced priority (range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- p0_req_valid / p1_req_valid  in  1  request valid
- p0_req_ready / p1_req_ready  out  1  grant; a request is accepted when valid & ready at a rising edge
- p0_req_addr / p1_req_addr  in  AW  byte address
- p0_req_we / p1_req_we  in  1  1 = store, 0 = load
- p0_req_size / p1_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- p0_req_sign / p1_req_sign  in  1  load sign-extend; ignored for stores and word loads
- p0_req_wdata / p1_req_wdata  in  32  store data, right-aligned
- p0_rsp_valid / p1_rsp_valid  out  1  one-cycle response pulse, no backpressure
- p0_rsp_rdata / p1_rsp_rdata  out  32  load result; 0 for stores and errors
- p0_rsp_err / p1_rsp_err  out  1  misaligned or illegal size
- mem_en  out  1  memory enable
- mem_we  out  4  byte write enables
- mem_addr  out  AW-2  word address
- mem_din  out  32  lane-shifted write data
- mem_dout  in  32  memory read data, valid the cycle after an enabled read

Behaviour:
- Reset (async, rst=1): all rsp_valid=0, rsp_err=0, rsp_rdata=0; wait counter=0; response pipeline register cleared. Outputs mem_en, mem_we and the ready signals are combinational and are 0 while no request is valid.
- Grant:
  - Default fixed priority: port 0 over port 1.
  - If wait_cnt >= HOST_MAX_WAIT and p1_req_valid, grant port 1.
  - At most one ready is high per cycle; ready is a combinational function of the valids and wait_cnt only.
- wait_cnt:
  - Increments each cycle that p1_req_valid=1 and p1 is not granted; saturates at 255.
  - Clears on p1 acceptance or when p1_req_valid=0.
- Error check at acceptance: err if size==3, (size==1 & addr[0]), or (size==2 & addr[1:0]!=0).
  - Erroring requests are accepted but drive mem_en=0, mem_we=0 (no memory side effect).
- Memory drive, same cycle as acceptance, for a non-error request:
  - mem_en=1; mem_addr=addr[AW-1:2].
  - Store: mem_we = byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; mem_din = wdata replicated or shifted into the addressed lanes.
  - Load: mem_we=0.
- Response pipeline register, captured at the accepting edge: valid, port id, err, we, size, sign, addr[1:0].
- Response cycle (cycle after acceptance):
  - The accepted port's rsp_valid=1.
  - Load: rdata = mem_dout >> (8*addr[1:0]), truncated to size, then sign- or zero-extended.
  - Store or err: rdata=0.
  - rsp_err per the error check.
- Latency and throughput: fixed 1-cycle latency; back-to-back acceptances every cycle, with responses pipelined one per cycle.
- Simultaneous events: both valid with wait_cnt < HOST_MAX_WAIT → port 0 granted and wait_cnt increments.
- Requester withdraws valid before acceptance: nothing issued and no response.
- Reset mid-operation: a response pending in the register is dropped (no rsp_valid). A store issued at the edge before reset is not rolled back.

Decomposition:
- Package ama_riscv_dmem_pkg holds:
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2
  - port ids P_CORE=0, P_HOST=1
  - the width of the response-register fields
- Sub-module ama_riscv_dmem_align: combinational store lane shift/byte-enable generation and load extract/extend. This block instantiates it once for each direction of use.

Test Plan:
- p0 store word 0xDEADBEEF @0x0010, then p0 load word @0x0010 → mem_we=4'hF, mem_addr=0x004; load rsp next cycle, rdata=0xDEADBEEF, err=0.
- p0 store byte 0x80 @0x0013; load byte signed @0x0013 → mem_we=4'b1000; rdata=0xFFFFFF80. Unsigned load → 0x00000080.
- p0 half load @0x0011 → p0 rsp_valid=1, rsp_err=1, rdata=0, mem_en=0 during acceptance; memory contents unchanged.
- p0 and p1 valid continuously, HOST_MAX_WAIT=8 → p0 granted 8 cycles, p1 granted on cycle 9, wait_cnt back to 0, p0 resumes.
- Back-to-back p0 load @0x20 then p1 load @0x24 → responses on consecutive cycles, each routed to the correct port with the correct data.
- Assert rst in the cycle after a load acceptance → no rsp_valid, all outputs 0, wait_cnt=0; a normal load after reset release responds correctly.
